// File: rtl/prog_ram_loader.sv
// prog_ram_loader: byte-stream loaded 2^DEPTH_LOG2 x 21-bit instruction store.
// It replaces the fixed instruction ROM. The CPU sees RESET_INS until a
// complete program has been written. After that, INS = mem[Addr] combinationally.
module prog_ram_loader #(
    parameter int                DEPTH_LOG2 = 8,
    parameter int                WORD_W     = 21,
    parameter logic [WORD_W-1:0] RESET_INS  = 21'b000011100000011111111
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  LOAD_START,
    input  logic [7:0]            BYTE_IN,
    input  logic                  BYTE_VALID,
    output logic                  BYTE_READY,
    input  logic [DEPTH_LOG2-1:0] Addr,
    output logic [WORD_W-1:0]     INS,
    output logic                  CPU_HOLD,
    output logic [DEPTH_LOG2-1:0] LOAD_ADDR,
    output logic                  LOAD_DONE,
    output logic                  FMT_ERR
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        HDR  = 3'd1,
        B0   = 3'd2,
        B1   = 3'd3,
        B2   = 3'd4,
        DONE = 3'd5
    } state_t;

    state_t              state, state_nx;
    logic                acc;
    logic [8:0]          cnt;
    logic [4:0]          hi;
    logic [7:0]          mid;
    logic [WORD_W-1:0]   wr_word;
    logic [WORD_W-1:0]   mem [0:(1<<DEPTH_LOG2)-1];

    // The word is packed as 5 high bits, a middle byte, then the low byte.
    assign wr_word   = {hi, mid, BYTE_IN};
    assign CPU_HOLD  = (state != DONE);
    assign LOAD_DONE = (state == DONE);
    assign INS       = CPU_HOLD ? RESET_INS : mem[Addr];

    // State register.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic and handshake. LOAD_START overrides any byte in the same cycle.
    always_comb begin
        state_nx   = state;
        BYTE_READY = 1'b0;
        acc        = 1'b0;
        BYTE_READY = ((state == HDR) || (state == B0) || (state == B1) || (state == B2))
                     && !LOAD_START;
        acc        = BYTE_VALID && BYTE_READY;
        if (LOAD_START) begin
            state_nx = HDR;
        end else if (acc) begin
            case (state)
                HDR:     state_nx = B0;
                B0:      state_nx = B1;
                B1:      state_nx = B2;
                B2:      state_nx = (cnt == 9'd1) ? DONE : B0;
                default: state_nx = state;
            endcase
        end
    end

    // Load bookkeeping: word count, partial-word bytes, write pointer, format flag.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            LOAD_ADDR <= '0;
            cnt       <= '0;
            hi        <= '0;
            mid       <= '0;
            FMT_ERR   <= 1'b0;
        end else if (LOAD_START) begin
            LOAD_ADDR <= '0;
            FMT_ERR   <= 1'b0;
        end else if (acc) begin
            case (state)
                HDR: cnt <= (BYTE_IN == 8'd0) ? 9'd256 : {1'b0, BYTE_IN};
                B0: begin
                    hi <= BYTE_IN[4:0];
                    if (BYTE_IN[7:5] != 3'd0) begin
                        FMT_ERR <= 1'b1;
                    end
                end
                B1: mid <= BYTE_IN;
                B2: begin
                    LOAD_ADDR <= LOAD_ADDR + DEPTH_LOG2'(1);
                    cnt       <= cnt - 9'd1;
                end
                default: ;
            endcase
        end
    end

    // Instruction memory write. RESET does not clear the contents.
    always_ff @(posedge CLK) begin
        if (!RESET && acc && (state == B2)) begin
            mem[LOAD_ADDR] <= wr_word;
        end
    end

endmodule

// File: tb/tb_prog_ram_loader.sv
// Self-checking bench for prog_ram_loader. Expected instruction words go into
// a scoreboard queue as bytes are driven. They are compared against INS once
// the loader reports DONE.
module tb_prog_ram_loader;

    localparam logic [20:0] RST_INS = 21'b000011100000011111111;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        LOAD_START;
    logic [7:0]  BYTE_IN;
    logic        BYTE_VALID;
    logic        BYTE_READY;
    logic [7:0]  Addr;
    logic [20:0] INS;
    logic        CPU_HOLD;
    logic [7:0]  LOAD_ADDR;
    logic        LOAD_DONE;
    logic        FMT_ERR;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [20:0] model [0:255];
    logic [7:0]  sbq [$];
    logic [7:0]  stim [$];
    logic        fmt_exp;

    prog_ram_loader dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .LOAD_START (LOAD_START),
        .BYTE_IN    (BYTE_IN),
        .BYTE_VALID (BYTE_VALID),
        .BYTE_READY (BYTE_READY),
        .Addr       (Addr),
        .INS        (INS),
        .CPU_HOLD   (CPU_HOLD),
        .LOAD_ADDR  (LOAD_ADDR),
        .LOAD_DONE  (LOAD_DONE),
        .FMT_ERR    (FMT_ERR)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h", tag, obs, exp);
        end
    endtask

    // Present one byte after 'gap' idle cycles and wait for it to be accepted.
    // The task is entered just after a negedge and returns on the negedge that follows the accepting posedge.
    task automatic put_byte(input logic [7:0] b, input int gap);
        int w;
        for (int i = 0; i < gap; i++) begin
            BYTE_VALID = 1'b0;
            @(negedge CLK);
        end
        BYTE_VALID = 1'b1;
        BYTE_IN    = b;
        w = 0;
        #1;
        while (!BYTE_READY && w < 20) begin
            @(negedge CLK);
            #1;
            w++;
        end
        if (w >= 20) check("ready_timeout", 32'(BYTE_READY), 32'd1);
        @(negedge CLK);
        BYTE_VALID = 1'b0;
    endtask

    task automatic load_start();
        @(negedge CLK);
        LOAD_START = 1'b1;
        #1;
        check("rdy_at_start", 32'(BYTE_READY), 32'd0);
        @(negedge CLK);
        LOAD_START = 1'b0;
        #1;
        check("rdy_after_start", 32'(BYTE_READY), 32'd1);
        check("hold_after_start", 32'(CPU_HOLD), 32'd1);
        check("addr_after_start", 32'(LOAD_ADDR), 32'd0);
        sbq.delete();
        fmt_exp = 1'b0;
    endtask

    // Send the first nbytes of stim and update the reference model as words complete.
    task automatic run_load(input int gap, input int nbytes);
        int          h;
        int          wa;
        logic [7:0]  b0;
        logic [7:0]  b1;
        wa = 0;
        b0 = '0;
        b1 = '0;
        h  = (stim[0] == 8'd0) ? 256 : int'(stim[0]);
        for (int k = 0; k < nbytes; k++) begin
            put_byte(stim[k], (k == 0) ? 0 : gap);
            if (k > 0) begin
                case ((k - 1) % 3)
                    0: begin
                        b0 = stim[k];
                        if (b0[7:5] != 3'd0) fmt_exp = 1'b1;
                    end
                    1: b1 = stim[k];
                    default: begin
                        model[wa[7:0]] = {b0[4:0], b1, stim[k]};
                        sbq.push_back(wa[7:0]);
                        wa++;
                    end
                endcase
            end
            check("load_addr", 32'(LOAD_ADDR), 32'(wa[7:0]));
            check("load_done", 32'(LOAD_DONE), 32'(wa == h));
            check("cpu_hold", 32'(CPU_HOLD), 32'(wa != h));
        end
        check("fmt_err", 32'(FMT_ERR), 32'(fmt_exp));
    endtask

    // Pop the scoreboard and compare INS at each written address.
    task automatic drain();
        logic [7:0] a;
        while (sbq.size() > 0) begin
            a = sbq.pop_front();
            Addr = a;
            #1;
            check("ins", 32'(INS), 32'(model[a]));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        RESET      = 1'b1;
        LOAD_START = 1'b0;
        BYTE_IN    = '0;
        BYTE_VALID = 1'b0;
        Addr       = '0;
        fmt_exp    = 1'b0;

        // Reset
        repeat (2) @(negedge CLK);
        RESET = 1'b0;
        #1;
        check("rst_hold", 32'(CPU_HOLD), 32'd1);
        check("rst_ins", 32'(INS), 32'(RST_INS));
        check("rst_ready", 32'(BYTE_READY), 32'd0);
        check("rst_addr", 32'(LOAD_ADDR), 32'd0);
        check("rst_done", 32'(LOAD_DONE), 32'd0);
        check("rst_fmt", 32'(FMT_ERR), 32'd0);

        // 3-word load, back-to-back
        load_start();
        stim = '{8'h03, 8'h0C, 8'h00, 8'h00, 8'h1C, 8'h03, 8'h01, 8'h16, 8'h03, 8'h0F};
        run_load(0, 10);
        Addr = 8'd0; #1; check("w0_const", 32'(INS), 32'h0C0000);
        Addr = 8'd1; #1; check("w1_const", 32'(INS), 32'h1C0301);
        Addr = 8'd2; #1; check("w2_const", 32'(INS), 32'h16030F);
        drain();

        // Stalled valid: 1,0,0,1,0,0,...
        load_start();
        run_load(2, 10);
        drain();

        // Restart mid-load, then a one-word load with a format error
        load_start();
        stim = '{8'h04, 8'h01, 8'h23, 8'h45, 8'h02, 8'h34, 8'h56, 8'h03};
        run_load(0, 8);
        load_start();
        stim = '{8'h01, 8'hE5, 8'hAA, 8'h55};
        run_load(0, 4);
        Addr = 8'd0; #1; check("restart_w0", 32'(INS), 32'h05AA55);
        Addr = 8'd1; #1; check("restart_w1_kept", 32'(INS), 32'h023456);
        drain();

        // Header 00: 256 words, LOAD_ADDR wraps to 0 on entering DONE
        load_start();
        stim.delete();
        stim.push_back(8'h00);
        for (int i = 0; i < 768; i++) stim.push_back(8'($urandom_range(0, 255)));
        run_load(0, 769);
        drain();

        // LOAD_START together with a valid byte in DONE: restart, byte dropped
        @(negedge CLK);
        LOAD_START = 1'b1;
        BYTE_VALID = 1'b1;
        BYTE_IN    = 8'h03;
        #1;
        check("dn_start_ready", 32'(BYTE_READY), 32'd0);
        @(negedge CLK);
        LOAD_START = 1'b0;
        BYTE_VALID = 1'b0;
        #1;
        check("dn_start_hold", 32'(CPU_HOLD), 32'd1);
        check("dn_start_addr", 32'(LOAD_ADDR), 32'd0);
        sbq.delete();
        fmt_exp = 1'b0;

        // Reset mid-load after 5 bytes
        stim = '{8'h03, 8'h0A, 8'h0B, 8'h0C, 8'h0D};
        run_load(0, 5);
        RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
        #1;
        check("mid_rst_hold", 32'(CPU_HOLD), 32'd1);
        check("mid_rst_ready", 32'(BYTE_READY), 32'd0);
        check("mid_rst_addr", 32'(LOAD_ADDR), 32'd0);
        check("mid_rst_done", 32'(LOAD_DONE), 32'd0);
        Addr = 8'd0; #1; check("mid_rst_ins0", 32'(INS), 32'(RST_INS));
        Addr = 8'd1; #1; check("mid_rst_ins1", 32'(INS), 32'(RST_INS));
        @(negedge CLK);
        check("idle_ready", 32'(BYTE_READY), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
